idex_dump_unit: RTL and testbench

Debug-side reader for the ID/EX pipeline latch. On a dump request it freezes the pipeline through `o_dunit_clk_en`, snapshots the five ID/EX output fields and streams them as a fixed 21-byte frame over a valid/ready byte interface toward the debug UART transmitter. When the frame is done it releases the pipeline and pulses `o_done`. It sits between the ID_EX latch outputs and the debug unit's TX path.

---
 rtl/idex_dump_unit_pkg.sv | 14 +
 rtl/dump_byte_sel.sv | 24 ++
 rtl/idex_dump_unit.sv | 97 +++++++++
 tb/tb_idex_dump_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/idex_dump_unit_pkg.sv
// rtl/idex_dump_unit_pkg.sv - shared constants and state encoding for the pipeline-latch dumpers
package idex_dump_unit_pkg;

  localparam logic [7:0] DUMP_HDR       = 8'hA5;
  localparam int         IDEX_FRAME_LEN = 21;
  localparam int         DUMP_CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/dump_byte_sel.sv
// rtl/dump_byte_sel.sv - picks frame byte[cnt]: header at 0, then snapshot bytes MSB first
module dump_byte_sel #(
  parameter int NB_BYTE   = 8,
  parameter int FRAME_LEN = 21,
  parameter int CNT_W     = 5,
  localparam int SNAP_W   = (FRAME_LEN - 1) * NB_BYTE
) (
  input  logic [SNAP_W-1:0]  i_snapshot,
  input  logic [NB_BYTE-1:0] i_header,
  input  logic [CNT_W-1:0]   i_cnt,
  output logic [NB_BYTE-1:0] o_byte
);

  // Byte 0 is the header; byte i (i>=1) is the (i-1)-th byte counted from the snapshot MSB.
  always_comb begin
    o_byte = i_header;
    for (int i = 1; i < FRAME_LEN; i++) begin
      if (i_cnt == CNT_W'(i)) begin
        o_byte = i_snapshot[SNAP_W-1-(i-1)*NB_BYTE -: NB_BYTE];
      end
    end
  end

endmodule

// File: rtl/idex_dump_unit.sv
// rtl/idex_dump_unit.sv - freezes the pipeline and streams an ID/EX latch snapshot as a 21-byte frame
module idex_dump_unit
  import idex_dump_unit_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_CTRL = 18,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dump_req,
  input  logic [NB_REG-1:0]  i_pc_eight,
  input  logic [NB_REG-1:0]  i_rs_data,
  input  logic [NB_REG-1:0]  i_rt_data,
  input  logic [NB_REG-1:0]  i_sign_extension,
  input  logic [NB_CTRL-1:0] i_control_unit,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_dunit_clk_en
);

  localparam int SNAP_W = (IDEX_FRAME_LEN - 1) * NB_BYTE;

  dump_state_e               state_q, state_d;
  logic [DUMP_CNT_W-1:0]     cnt_q, cnt_d;
  logic [SNAP_W-1:0]         snap_q, snap_d;
  logic [NB_BYTE-1:0]        sel_byte;
  logic                      last_byte;
  logic                      xfer;

  assign last_byte = (cnt_q == DUMP_CNT_W'(IDEX_FRAME_LEN - 1));
  assign xfer      = (state_q == ST_SEND) && i_tx_ready;

  // State, counter and snapshot registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  // Next-state logic: capture on request in IDLE, advance on each accepted byte, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_dump_req) begin
          state_d = ST_SEND;
          cnt_d   = '0;
          snap_d  = {i_pc_eight, i_rs_data, i_rt_data, i_sign_extension, 32'(i_control_unit)};
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (last_byte) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  dump_byte_sel #(
    .NB_BYTE  (NB_BYTE),
    .FRAME_LEN(IDEX_FRAME_LEN),
    .CNT_W    (DUMP_CNT_W)
  ) u_byte_sel (
    .i_snapshot(snap_q),
    .i_header  (NB_BYTE'(DUMP_HDR)),
    .i_cnt     (cnt_q),
    .o_byte    (sel_byte)
  );

  // Outputs decoded from registered state only; data is forced to zero outside SEND.
  always_comb begin
    o_tx_valid     = (state_q == ST_SEND);
    o_tx_data      = (state_q == ST_SEND) ? sel_byte : '0;
    o_busy         = (state_q != ST_IDLE);
    o_done         = (state_q == ST_DONE);
    o_dunit_clk_en = (state_q == ST_IDLE);
  end

endmodule

// File: tb/tb_idex_dump_unit.sv
// tb/tb_idex_dump_unit.sv - randomized self-checking bench for idex_dump_unit
module tb_idex_dump_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_dump_req = 1'b0;
  logic [31:0] i_pc_eight = '0, i_rs_data = '0, i_rt_data = '0, i_sign_extension = '0;
  logic [17:0] i_control_unit = '0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic        o_busy, o_done, o_dunit_clk_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_b [0:20];
  logic [7:0] cap_bytes [0:63];
  int cap_n, cap_done_cyc, cap_done_cnt, cap_clken_low, cap_unstable, cap_exp_done;
  bit cap_idle_after;

  idex_dump_unit dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_dump_req      (i_dump_req),
    .i_pc_eight      (i_pc_eight),
    .i_rs_data       (i_rs_data),
    .i_rt_data       (i_rt_data),
    .i_sign_extension(i_sign_extension),
    .i_control_unit  (i_control_unit),
    .o_tx_data       (o_tx_data),
    .o_tx_valid      (o_tx_valid),
    .i_tx_ready      (i_tx_ready),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_dunit_clk_en  (o_dunit_clk_en)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference frame: header, then five 32-bit words MSB first, control zero-extended.
  task automatic build_frame(input logic [31:0] pc, rs, rt, sx, input logic [17:0] ctrl);
    logic [31:0] w [0:4];
    w[0] = pc; w[1] = rs; w[2] = rt; w[3] = sx; w[4] = {14'b0, ctrl};
    exp_b[0] = 8'hA5;
    for (int k = 0; k < 5; k++)
      for (int b = 0; b < 4; b++)
        exp_b[1 + 4*k + b] = 8'((w[k] >> (24 - 8*b)) & 32'hFF);
  endtask

  task automatic set_inputs(input logic [31:0] pc, rs, rt, sx, input logic [17:0] ctrl);
    i_pc_eight = pc; i_rs_data = rs; i_rt_data = rt; i_sign_extension = sx; i_control_unit = ctrl;
    build_frame(pc, rs, rt, sx, ctrl);
  endtask

  // Issues one request and records what the DUT emits; pat 0=ready high, 1=toggle from 0, 2=random.
  task automatic capture_frame(input int pat, input bit chg, input bit breq);
    int midx;
    bit rdy, hold_pending;
    logic [7:0] prev_data;
    cap_n = 0; cap_done_cyc = 0; cap_done_cnt = 0; cap_clken_low = 0; cap_unstable = 0;
    cap_exp_done = 0; hold_pending = 1'b0; prev_data = '0; midx = 0;
    i_dump_req = 1'b1;
    @(posedge i_clk); #1;
    i_dump_req = 1'b0;
    if (chg) begin
      i_pc_eight = 32'h11111111; i_rs_data = 32'h22222222; i_rt_data = 32'h33333333;
      i_sign_extension = 32'h44444444; i_control_unit = 18'h0F0F0;
    end
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (!o_dunit_clk_en) cap_clken_low++;
      if (o_done) begin
        cap_done_cnt++;
        if (cap_done_cyc == 0) cap_done_cyc = cyc;
      end
      if (o_tx_valid && hold_pending && (o_tx_data !== prev_data)) cap_unstable++;
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_dump_req = breq && ((midx < 21 && (midx == 3 || midx == 20)) ||
                            (midx == 21 && cyc == cap_exp_done));
      if (midx < 21) begin
        if (rdy) midx++;
        if (midx == 21) cap_exp_done = cyc + 1;
      end
      i_tx_ready = rdy;
      if (o_tx_valid && rdy) begin
        if (cap_n < 64) cap_bytes[cap_n] = o_tx_data;
        cap_n++;
      end
      hold_pending = o_tx_valid && !rdy;
      prev_data = o_tx_data;
      if (cap_exp_done != 0 && cyc >= cap_exp_done + 3) break;
      @(posedge i_clk); #1;
    end
    cap_idle_after = !o_busy && o_dunit_clk_en && !o_tx_valid;
    i_tx_ready = 1'b0;
    i_dump_req = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++; if (o_tx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", o_tx_valid); end
    n_checks++; if (o_tx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", o_tx_data); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
    n_checks++; if (o_dunit_clk_en !== 1'b1) begin n_errors++; $display("FAIL reset_clk_en: got %b expected 1", o_dunit_clk_en); end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    set_inputs($urandom, $urandom, $urandom, $urandom, 18'($urandom));
    i_dump_req = 1'b1;
    @(posedge i_clk); #1;
    i_dump_req = 1'b0;
    i_tx_ready = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    n_checks++; if (o_tx_data !== exp_b[5]) begin n_errors++; $display("FAIL midframe_byte5: got %h expected %h", o_tx_data, exp_b[5]); end
    i_reset = 1'b0;
    #1;
    n_checks++; if (o_tx_valid !== 1'b0) begin n_errors++; $display("FAIL abort_valid: got %b expected 0", o_tx_valid); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
    n_checks++; if (o_dunit_clk_en !== 1'b1) begin n_errors++; $display("FAIL abort_clk_en: got %b expected 1", o_dunit_clk_en); end
    i_tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL abort_no_done: got %b expected 0", o_done); end
    end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    set_inputs($urandom, $urandom, $urandom, $urandom, 18'($urandom));
    capture_frame(0, 1'b0, 1'b0);
    n_checks++; if (cap_n !== 21) begin n_errors++; $display("FAIL restart_len: got %0d expected 21", cap_n); end
    for (int i = 0; i < 21; i++) begin
      n_checks++; if (cap_bytes[i] !== exp_b[i]) begin n_errors++; $display("FAIL restart_byte%0d: got %h expected %h", i, cap_bytes[i], exp_b[i]); end
    end
  endtask

  task automatic test_full_frame;
    set_inputs(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h12345678, 18'h3FFFF);
    capture_frame(0, 1'b0, 1'b0);
    n_checks++; if (cap_n !== 21) begin n_errors++; $display("FAIL full_len: got %0d expected 21", cap_n); end
    for (int i = 0; i < 21; i++) begin
      n_checks++; if (cap_bytes[i] !== exp_b[i]) begin n_errors++; $display("FAIL full_byte%0d: got %h expected %h", i, cap_bytes[i], exp_b[i]); end
    end
    n_checks++; if (cap_done_cyc !== 22) begin n_errors++; $display("FAIL full_done_cycle: got k+%0d expected k+22", cap_done_cyc); end
    n_checks++; if (cap_done_cnt !== 1) begin n_errors++; $display("FAIL full_done_count: got %0d expected 1", cap_done_cnt); end
    n_checks++; if (cap_clken_low !== 22) begin n_errors++; $display("FAIL clk_en_low_cycles: got %0d expected 22", cap_clken_low); end
    n_checks++; if (cap_idle_after !== 1'b1) begin n_errors++; $display("FAIL full_idle_after: got %b expected 1", cap_idle_after); end
  endtask

  task automatic test_backpressure;
    set_inputs($urandom, $urandom, $urandom, $urandom, 18'($urandom));
    capture_frame(1, 1'b0, 1'b0);
    n_checks++; if (cap_n !== 21) begin n_errors++; $display("FAIL bp_len: got %0d expected 21", cap_n); end
    for (int i = 0; i < 21; i++) begin
      n_checks++; if (cap_bytes[i] !== exp_b[i]) begin n_errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, cap_bytes[i], exp_b[i]); end
    end
    n_checks++; if (cap_done_cyc !== 43) begin n_errors++; $display("FAIL bp_done_cycle: got k+%0d expected k+43", cap_done_cyc); end
    n_checks++; if (cap_unstable !== 0) begin n_errors++; $display("FAIL bp_data_stable: got %0d changes expected 0", cap_unstable); end
  endtask

  task automatic test_snapshot_isolation;
    set_inputs($urandom, $urandom, $urandom, $urandom, 18'($urandom));
    capture_frame(0, 1'b1, 1'b0);
    n_checks++; if (cap_n !== 21) begin n_errors++; $display("FAIL iso_len: got %0d expected 21", cap_n); end
    for (int i = 0; i < 21; i++) begin
      n_checks++; if (cap_bytes[i] !== exp_b[i]) begin n_errors++; $display("FAIL iso_byte%0d: got %h expected %h", i, cap_bytes[i], exp_b[i]); end
    end
  endtask

  task automatic test_request_while_busy;
    set_inputs($urandom, $urandom, $urandom, $urandom, 18'($urandom));
    capture_frame(0, 1'b0, 1'b1);
    n_checks++; if (cap_n !== 21) begin n_errors++; $display("FAIL busy_req_len: got %0d expected 21", cap_n); end
    n_checks++; if (cap_done_cnt !== 1) begin n_errors++; $display("FAIL busy_req_done_count: got %0d expected 1", cap_done_cnt); end
    n_checks++; if (cap_done_cyc !== 22) begin n_errors++; $display("FAIL busy_req_done_cycle: got k+%0d expected k+22", cap_done_cyc); end
    n_checks++; if (cap_idle_after !== 1'b1) begin n_errors++; $display("FAIL busy_req_idle_after: got %b expected 1", cap_idle_after); end
  endtask

  task automatic test_random_ready;
    for (int f = 0; f < 4; f++) begin
      set_inputs($urandom, $urandom, $urandom, $urandom, 18'($urandom));
      capture_frame(2, 1'b0, 1'b0);
      n_checks++; if (cap_n !== 21) begin n_errors++; $display("FAIL rnd%0d_len: got %0d expected 21", f, cap_n); end
      for (int i = 0; i < 21; i++) begin
        n_checks++; if (cap_bytes[i] !== exp_b[i]) begin n_errors++; $display("FAIL rnd%0d_byte%0d: got %h expected %h", f, i, cap_bytes[i], exp_b[i]); end
      end
      n_checks++; if (cap_done_cyc !== cap_exp_done) begin n_errors++; $display("FAIL rnd%0d_done_cycle: got k+%0d expected k+%0d", f, cap_done_cyc, cap_exp_done); end
      n_checks++; if (cap_unstable !== 0) begin n_errors++; $display("FAIL rnd%0d_data_stable: got %0d changes expected 0", f, cap_unstable); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_snapshot_isolation();
    test_request_while_busy();
    test_random_ready();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
